// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-ported load/store unit for a word-wide, big-endian data memory.
// Sub-word stores use a read-modify-write sequence (ACCESS reads, MERGE_WR writes).
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned halfword/word accesses are
// rejected with resp_err instead of touching memory.
module lsu_mem_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE_WR, S_RESP} state_t;

   state_t          state_q, state_n;
   logic            we_q, signed_q;
   logic [1:0]      size_q;
   logic [DW-1:0]   addr_q, wdata_q;
   logic            lat_req_c;
   logic            ready_q, ready_n, rvalid_q, rvalid_n, err_q, err_n, mwe_q, mwe_n;
   logic [DW-1:0]   rdata_q, rdata_n, ma_q, ma_n, mwd_q, mwd_n;
   logic            mis_req_c, mis_q_c;

   // Extract the addressed lane from a memory word and extend it to 32 bits.
   function automatic logic [DW-1:0] lane_load(input logic [DW-1:0] rd, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
      logic [7:0]    b;
      logic [15:0]   h;
      logic [DW-1:0] r;
      b = 8'(rd >> {~off, 3'b000});
      h = off[1] ? rd[15:0] : rd[31:16];
      case (size)
         2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/halfword lane of a memory word with store data.
   function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] rd, input logic [1:0] size,
                                                input logic [1:0] off, input logic [DW-1:0] wd);
      logic [4:0]    sh;
      logic [DW-1:0] mask, data;
      if (size == 2'b01) begin
         sh   = off[1] ? 5'd0 : 5'd16;
         mask = 32'h0000_FFFF << sh;
         data = {16'h0, wd[15:0]} << sh;
      end else begin
         sh   = {~off, 3'b000};
         mask = 32'h0000_00FF << sh;
         data = {24'h0, wd[7:0]} << sh;
      end
      return (rd & ~mask) | data;
   endfunction

   // Misalignment detection for the incoming and the latched request.
`ifdef LSU_ALIGN_CHECK_EN
   assign mis_req_c = ((req_size == 2'b01) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
   assign mis_q_c   = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
   assign mis_req_c = 1'b0;
   assign mis_q_c   = 1'b0;
`endif

   // Next-state and next-output decode; outputs are registered for the state being entered.
   always_comb begin
      state_n   = state_q;
      lat_req_c = 1'b0;
      ready_n   = 1'b0;
      rvalid_n  = 1'b0;
      rdata_n   = rdata_q;
      err_n     = err_q;
      mwe_n     = 1'b0;
      ma_n      = '0;
      mwd_n     = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               lat_req_c = 1'b1;
               state_n   = S_ACCESS;
               ma_n      = {req_addr[31:2], 2'b00};
               if (req_we && req_size[1] && !mis_req_c) begin
                  mwe_n = 1'b1;
                  mwd_n = req_wdata;
               end
            end else begin
               ready_n = 1'b1;
            end
         end
         S_ACCESS: begin
            if (!mis_q_c && we_q && !size_q[1]) begin
               state_n = S_MERGE_WR;
               ma_n    = ma_q;
               mwe_n   = 1'b1;
               mwd_n   = lane_merge(mem_RD, size_q, addr_q[1:0], wdata_q);
            end else begin
               state_n  = S_RESP;
               rvalid_n = 1'b1;
               err_n    = mis_q_c;
               rdata_n  = (mis_q_c || we_q) ? '0 : lane_load(mem_RD, size_q, addr_q[1:0], signed_q);
            end
         end
         S_MERGE_WR: begin
            state_n  = S_RESP;
            rvalid_n = 1'b1;
            err_n    = 1'b0;
            rdata_n  = '0;
         end
         S_RESP: begin
            state_n = S_IDLE;
            ready_n = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State, request latch and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         mwe_q    <= 1'b0;
         ma_q     <= '0;
         mwd_q    <= '0;
      end else begin
         state_q  <= state_n;
         if (lat_req_c) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
         ready_q  <= ready_n;
         rvalid_q <= rvalid_n;
         rdata_q  <= rdata_n;
         err_q    <= err_n;
         mwe_q    <= mwe_n;
         ma_q     <= ma_n;
         mwd_q    <= mwd_n;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = rvalid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_A      = ma_q;
   assign mem_WD     = mwd_q;
   // Reset gates the write enable so an aborted request never writes on the reset edge.
   assign mem_WE     = mwe_q & ~rst;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: behavioural big-endian memory, shadow memory model
// and a scoreboard of expected responses. Honors LSU_ALIGN_CHECK_EN when defined.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_WE;
   logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;

   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          writes;
      logic [31:0] wa;
      logic [31:0] wd;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mem    [0:63] = '{default: 32'h0};
   logic [31:0] shadow [0:63] = '{default: 32'h0};
   int          wr_cnt = 0;
   logic [31:0] last_a = '0, last_wd = '0;

   always #5 clk = ~clk;

   lsu_mem_port dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_A(mem_A),
      .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
   );

   // Data memory: combinational read, write on rising edge.
   assign mem_RD = mem[mem_A[7:2]];
   always @(posedge clk) begin
      if (mem_WE === 1'b1) begin
         mem[mem_A[7:2]] <= mem_WD;
         wr_cnt  <= wr_cnt + 1;
         last_a  <= mem_A;
         last_wd <= mem_WD;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
      logic [7:0]  b [4];
      logic [15:0] h;
      int          i;
      b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
      if (size == 2'b00) return sgn ? {{24{b[off][7]}}, b[off]} : {24'h0, b[off]};
      if (size == 2'b01) begin
         i = off[1] ? 2 : 0;
         h = {b[i], b[i+1]};
         return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      end
      return w;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] off, input logic [31:0] d);
      logic [7:0] b [4];
      int         i;
      if (size[1]) return d;
      b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
      if (size == 2'b00) b[off] = d[7:0];
      else begin
         i = off[1] ? 2 : 0;
         b[i] = d[15:8]; b[i+1] = d[7:0];
      end
      return {b[0], b[1], b[2], b[3]};
   endfunction

   function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
      return ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   // One complete request; hold=1 offers a junk store while the unit is busy.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
      exp_t e;
      int   idx, cyc, w0;
      idx = int'(addr[7:2]);
      e.wa = {addr[31:2], 2'b00};
      e.wd = '0;
      e.err = 1'b0;
      e.rdata = '0;
      e.writes = 0;
      e.lat = 2;
      if (ref_mis(size, addr)) begin
         e.err = 1'b1;
      end else if (!we) begin
         e.rdata = ref_load(shadow[idx], size, addr[1:0], sgn);
      end else begin
         e.wd = ref_store(shadow[idx], size, addr[1:0], wdata);
         shadow[idx] = e.wd;
         e.writes = 1;
         e.lat = size[1] ? 2 : 3;
      end
      sb.push_back(e);

      check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      if (hold) begin
         req_we = 1'b1; req_size = 2'b10; req_addr = 32'h3C; req_wdata = 32'hBAD0BAD0;
      end else begin
         req_valid = 1'b0;
      end
      cyc = 1;
      while (resp_valid !== 1'b1 && cyc < 8) begin
         check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = 1'b0;
      e = sb.pop_front();
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_err"}, 32'(resp_err), 32'(e.err));
      check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(e.writes));
      if (e.writes == 1) begin
         check({tag, "_wr_addr"}, last_a, e.wa);
         check({tag, "_wr_data"}, last_wd, e.wd);
      end
      @(posedge clk); #1;
      check({tag, "_resp_pulse"}, 32'(resp_valid), 32'd0);
      check({tag, "_rdata_held"}, resp_rdata, e.rdata);
      check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
      check({tag, "_we_idle"}, 32'(mem_WE), 32'd0);
   endtask

   // Start a store, then assert reset after n busy cycles (0: ACCESS, 1: MERGE_WR).
   task automatic abort_req(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int n);
      int w0;
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = size; req_signed = 1'b0;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check({tag, "_we_gated"}, 32'(mem_WE), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      check({tag, "_mem_A_zero"}, mem_A, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_no_resp"}, 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
      end
      check({tag, "_no_write"}, 32'(wr_cnt - w0), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_mem_WE", 32'(mem_WE), 32'd0);
      check("rst_mem_A", mem_A, 32'd0);
      check("rst_mem_WD", mem_WD, 32'd0);

      // Preload through word stores.
      do_req("pre10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
      do_req("pre20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b0);

      // Loads: every lane flavour, signed and unsigned.
      do_req("lb_s_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);
      do_req("lh_s_20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);
      do_req("lh_u_22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0);
      do_req("lb_s_20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0);
      do_req("lb_u_21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0);
      do_req("lb_s_23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0);
      do_req("lw_rsv", 1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 1'b1);

      // Sub-word stores and read-back.
      do_req("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB, 1'b0);
      do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b1);
      do_req("sh_20", 1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF5678, 1'b0);
      do_req("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

      // Word store and alignment-sensitive accesses.
      do_req("sw_04", 1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF, 1'b0);
      do_req("sw_06", 1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFEF00D, 1'b0);
      do_req("lw_04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0);
      do_req("lh_u_21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0);
      do_req("sh_13", 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 1'b0);
      do_req("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

      // Reset aborts: no write, no response, memory unchanged.
      abort_req("abort_merge", 2'b00, 32'h10, 32'h00000055, 1);
      abort_req("abort_access", 2'b10, 32'h04, 32'h01234567, 0);
      do_req("lw_10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
      do_req("lw_04b", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
